// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: round-robin between the CPU (p0) and a loader (p1),
// with a p1 lock mode bounded by a p0 starvation limit. Responses are registered.
module dmem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_WAIT   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [2:0]            p0_funct3,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_gnt,
    output logic                  p0_rvalid,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    output logic                  p0_err,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [2:0]            p1_funct3,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    input  logic                  p1_lock,
    output logic                  p1_gnt,
    output logic                  p1_rvalid,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic                  p1_err,
    output logic                  mem_wr_en,
    output logic [2:0]            mem_funct3,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);

    // state    | meaning
    // ST_ARB   | round-robin between p0 and p1
    // ST_LOCK1 | p1 owns the memory; p0 waits up to MAX_WAIT cycles
    typedef enum logic {ST_ARB, ST_LOCK1} state_t;

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    state_t                state_q, state_d;
    logic                  last_q, last_d;     // 1: p1 was granted last
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic                  p0_rvalid_q, p1_rvalid_q;
    logic [DATA_WIDTH-1:0] p0_rdata_q, p1_rdata_q;
    logic                  p0_err_q, p1_err_q;

    logic                  wait_full;
    logic                  sel_we;
    logic [2:0]            sel_f3;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  illegal;
    logic [DATA_WIDTH-1:0] resp_rdata;

    function automatic logic is_illegal(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            3'b000, 3'b100: is_illegal = 1'b0;
            3'b001, 3'b101: is_illegal = a[0];
            3'b010:         is_illegal = (a != 2'b00);
            default:        is_illegal = 1'b1;
        endcase
    endfunction

    assign wait_full = (wait_q == WAIT_W'(MAX_WAIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ARB;
            last_q      <= 1'b1;
            wait_q      <= '0;
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
            p0_err_q    <= 1'b0;
            p1_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            wait_q      <= wait_d;
            p0_rvalid_q <= p0_gnt;
            p1_rvalid_q <= p1_gnt;
            if (p0_gnt) begin
                p0_rdata_q <= resp_rdata;
                p0_err_q   <= illegal;
            end
            if (p1_gnt) begin
                p1_rdata_q <= resp_rdata;
                p1_err_q   <= illegal;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        wait_d  = wait_q;
        if (p0_gnt) last_d = 1'b0;
        if (p1_gnt) last_d = 1'b1;
        case (state_q)
            ST_ARB: begin
                wait_d = '0;
                if (p1_gnt && p1_lock) state_d = ST_LOCK1;
            end
            ST_LOCK1: begin
                if (p1_gnt && p1_lock) begin
                    wait_d = p0_req ? wait_q + WAIT_W'(1) : '0;
                end else begin
                    state_d = ST_ARB;
                    wait_d  = '0;
                end
            end
            default: begin
                state_d = ST_ARB;
                wait_d  = '0;
            end
        endcase
    end

    // Grants are combinational and suppressed while reset is asserted.
    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_ARB: begin
                    if (p0_req && p1_req) begin
                        p0_gnt = last_q;
                        p1_gnt = ~last_q;
                    end else begin
                        p0_gnt = p0_req;
                        p1_gnt = p1_req;
                    end
                end
                ST_LOCK1: begin
                    if (p0_req && wait_full) p0_gnt = 1'b1;
                    else if (p1_req)         p1_gnt = 1'b1;
                    else                     p0_gnt = p0_req;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_f3    = 3'b010;
        sel_addr  = '0;
        sel_wdata = '0;
        if (p0_gnt) begin
            sel_we    = p0_we;
            sel_f3    = p0_funct3;
            sel_addr  = p0_addr;
            sel_wdata = p0_wdata;
        end else if (p1_gnt) begin
            sel_we    = p1_we;
            sel_f3    = p1_funct3;
            sel_addr  = p1_addr;
            sel_wdata = p1_wdata;
        end
        illegal     = is_illegal(sel_f3, sel_addr[1:0]);
        mem_wr_en   = sel_we & ~illegal;
        mem_funct3  = sel_f3;
        mem_addr    = sel_addr;
        mem_wr_data = sel_wdata;
        resp_rdata  = (sel_we || illegal) ? '0 : mem_rd_data;
    end

    assign p0_rvalid = p0_rvalid_q;
    assign p1_rvalid = p1_rvalid_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;
    assign p0_err    = p0_err_q;
    assign p1_err    = p1_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: drivers push expected grants/responses into queues,
// a negedge monitor pops and compares them. Includes a small byte-lane memory model.
module tb_dmem_arbiter;

    localparam int MAXC = 50;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    logic        clk, rst;
    logic        p0_req, p0_we, p0_gnt, p0_rvalid, p0_err;
    logic [2:0]  p0_funct3;
    logic [31:0] p0_addr, p0_wdata, p0_rdata;
    logic        p1_req, p1_we, p1_gnt, p1_rvalid, p1_err, p1_lock;
    logic [2:0]  p1_funct3;
    logic [31:0] p1_addr, p1_wdata, p1_rdata;
    logic        mem_wr_en;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_addr, mem_wr_data, mem_rd_data;

    int vectors = 0;
    int miscompares = 0;

    resp_t exp0_q[$];
    resp_t exp1_q[$];
    int    gnt_q[$];

    dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_WAIT(8)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_funct3(p0_funct3), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_funct3(p1_funct3), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_lock(p1_lock), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
        .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_wr_en(mem_wr_en), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: 64 words, RV32 byte lanes and load extension.
    logic [31:0] tb_mem [0:63];
    logic        mem_clr;
    logic [31:0] mw;
    logic [7:0]  mb;
    logic [15:0] mh;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) tb_mem[i] <= 32'h0;
        end else if (mem_wr_en) begin
            case (mem_funct3[1:0])
                2'b00:   tb_mem[mem_addr[7:2]][{mem_addr[1:0], 3'b000} +: 8] <= mem_wr_data[7:0];
                2'b01:   tb_mem[mem_addr[7:2]][{mem_addr[1], 4'b0000} +: 16] <= mem_wr_data[15:0];
                default: tb_mem[mem_addr[7:2]] <= mem_wr_data;
            endcase
        end
    end

    always_comb begin
        mw = tb_mem[mem_addr[7:2]];
        mb = mw[{mem_addr[1:0], 3'b000} +: 8];
        mh = mw[{mem_addr[1], 4'b0000} +: 16];
        case (mem_funct3)
            3'b000:  mem_rd_data = {{24{mb[7]}}, mb};
            3'b100:  mem_rd_data = {24'h0, mb};
            3'b001:  mem_rd_data = {{16{mh[15]}}, mh};
            3'b101:  mem_rd_data = {16'h0, mh};
            default: mem_rd_data = mw;
        endcase
    end

    function void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endfunction

    // Drive one request on a port, hold until granted, then release.
    task automatic issue(input int port, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic lock,
                         input logic [31:0] exp_rd, input logic exp_err, input logic exp_wen);
        resp_t r;
        int    n;
        logic  g;
        r.rdata = exp_rd;
        r.err   = exp_err;
        if (port == 0) begin
            exp0_q.push_back(r);
            p0_we = we; p0_funct3 = f3; p0_addr = addr; p0_wdata = wdata; p0_req = 1'b1;
        end else begin
            exp1_q.push_back(r);
            p1_we = we; p1_funct3 = f3; p1_addr = addr; p1_wdata = wdata; p1_lock = lock;
            p1_req = 1'b1;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
            g = (port == 0) ? p0_gnt : p1_gnt;
        end while (!g && n < MAXC);
        if (!g) begin
            check(port == 0 ? "p0_gnt_timeout" : "p1_gnt_timeout", 32'd0, 32'd1);
        end else begin
            check("mem_wr_en", {31'b0, mem_wr_en}, {31'b0, exp_wen});
            check("mem_addr", mem_addr, addr);
        end
        @(posedge clk);
        #1;
        if (port == 0) p0_req = 1'b0;
        else           p1_req = 1'b0;
    endtask

    // Monitor: grant order, response contents and one-cycle response latency.
    logic  prev_g0 = 1'b0, prev_g1 = 1'b0;
    resp_t mon_r;
    int    mon_p;

    always @(negedge clk) begin
        if (p0_gnt || p1_gnt) begin
            check("gnt_onehot", {31'b0, p0_gnt & p1_gnt}, 32'd0);
            if (gnt_q.size() == 0) begin
                check("gnt_unexpected", {30'b0, p1_gnt, p0_gnt}, 32'd0);
            end else begin
                mon_p = gnt_q.pop_front();
                check("gnt_order", {31'b0, p1_gnt}, mon_p);
            end
        end
        if (p0_rvalid) begin
            if (exp0_q.size() == 0) check("p0_rvalid_unexpected", 32'd1, 32'd0);
            else begin
                mon_r = exp0_q.pop_front();
                check("p0_rdata", p0_rdata, mon_r.rdata);
                check("p0_err", {31'b0, p0_err}, {31'b0, mon_r.err});
            end
        end
        if (p1_rvalid) begin
            if (exp1_q.size() == 0) check("p1_rvalid_unexpected", 32'd1, 32'd0);
            else begin
                mon_r = exp1_q.pop_front();
                check("p1_rdata", p1_rdata, mon_r.rdata);
                check("p1_err", {31'b0, p1_err}, {31'b0, mon_r.err});
            end
        end
        if (p0_rvalid || prev_g0) check("p0_rvalid_latency", {31'b0, p0_rvalid}, {31'b0, prev_g0});
        if (p1_rvalid || prev_g1) check("p1_rvalid_latency", {31'b0, p1_rvalid}, {31'b0, prev_g1});
        prev_g0 = p0_gnt;
        prev_g1 = p1_gnt;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; mem_clr = 1'b1;
        p0_req = 0; p0_we = 0; p0_funct3 = 3'b010; p0_addr = 0; p0_wdata = 0;
        p1_req = 0; p1_we = 0; p1_funct3 = 3'b010; p1_addr = 0; p1_wdata = 0; p1_lock = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; mem_clr = 1'b0;

        // Reset state and idle memory bus
        @(negedge clk);
        check("rst_p0_rvalid", {31'b0, p0_rvalid}, 32'd0);
        check("rst_p1_rvalid", {31'b0, p1_rvalid}, 32'd0);
        check("rst_p0_rdata", p0_rdata, 32'd0);
        check("rst_p1_rdata", p1_rdata, 32'd0);
        check("rst_p0_err", {31'b0, p0_err}, 32'd0);
        check("rst_p1_err", {31'b0, p1_err}, 32'd0);
        check("idle_wr_en", {31'b0, mem_wr_en}, 32'd0);
        check("idle_funct3", {29'b0, mem_funct3}, 32'd2);
        check("idle_addr", mem_addr, 32'd0);
        check("idle_wdata", mem_wr_data, 32'd0);
        @(posedge clk);
        #1;

        // Both ports back-to-back: p0 wins the first tie, then alternate
        gnt_q.push_back(0); gnt_q.push_back(1); gnt_q.push_back(0); gnt_q.push_back(1);
        fork
            begin
                issue(0, 1'b1, 3'b010, 32'h10, 32'h11, 1'b0, 32'h0, 1'b0, 1'b1);
                issue(0, 1'b1, 3'b010, 32'h14, 32'h33, 1'b0, 32'h0, 1'b0, 1'b1);
            end
            begin
                issue(1, 1'b1, 3'b010, 32'h20, 32'h22, 1'b0, 32'h0, 1'b0, 1'b1);
                issue(1, 1'b1, 3'b010, 32'h24, 32'h44, 1'b0, 32'h0, 1'b0, 1'b1);
            end
        join
        gnt_q.push_back(0); gnt_q.push_back(1);
        fork
            issue(0, 1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 32'h22, 1'b0, 1'b0);
            issue(1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h11, 1'b0, 1'b0);
        join

        // Sub-word loads
        gnt_q.push_back(0); gnt_q.push_back(0); gnt_q.push_back(0);
        issue(0, 1'b1, 3'b010, 32'h8, 32'h12345678, 1'b0, 32'h0, 1'b0, 1'b1);
        issue(0, 1'b0, 3'b001, 32'hA, 32'h0, 1'b0, 32'h00001234, 1'b0, 1'b0);
        issue(0, 1'b0, 3'b000, 32'hB, 32'h0, 1'b0, 32'h00000012, 1'b0, 1'b0);

        // Misaligned store is granted but does not write
        gnt_q.push_back(0); gnt_q.push_back(0); gnt_q.push_back(0);
        issue(0, 1'b1, 3'b010, 32'h4, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0, 1'b1);
        issue(0, 1'b1, 3'b010, 32'h6, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1, 1'b0);
        issue(0, 1'b0, 3'b010, 32'h4, 32'h0, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0);

        // Illegal funct3 load
        gnt_q.push_back(1);
        issue(1, 1'b0, 3'b011, 32'h4, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);

        // Reset during an SB request: no grant, no write, outputs cleared
        rst = 1'b1;
        p0_we = 1'b1; p0_funct3 = 3'b000; p0_addr = 32'h4; p0_wdata = 32'hAA; p0_req = 1'b1;
        @(negedge clk);
        check("rst_p0_gnt", {31'b0, p0_gnt}, 32'd0);
        check("rst_p1_gnt", {31'b0, p1_gnt}, 32'd0);
        check("rst_wr_en", {31'b0, mem_wr_en}, 32'd0);
        @(posedge clk);
        #1;
        check("rst2_p0_rvalid", {31'b0, p0_rvalid}, 32'd0);
        check("rst2_p0_rdata", p0_rdata, 32'd0);
        check("rst2_p0_err", {31'b0, p0_err}, 32'd0);
        check("rst2_p1_rvalid", {31'b0, p1_rvalid}, 32'd0);
        check("rst2_p1_rdata", p1_rdata, 32'd0);
        check("rst2_p1_err", {31'b0, p1_err}, 32'd0);
        check("rst2_mem_word", tb_mem[1], 32'hCAFEF00D);
        rst = 1'b0;
        gnt_q.push_back(0); gnt_q.push_back(0);
        issue(0, 1'b1, 3'b000, 32'h4, 32'hAA, 1'b0, 32'h0, 1'b0, 1'b1);
        issue(0, 1'b0, 3'b010, 32'h4, 32'h0, 1'b0, 32'hCAFEF0AA, 1'b0, 1'b0);

        // p1 lock burst of 12; p0 waits from burst cycle 2 and is forced in after 8 cycles
        for (int i = 0; i < 9; i++) gnt_q.push_back(1);
        gnt_q.push_back(0);
        for (int i = 0; i < 3; i++) gnt_q.push_back(1);
        fork
            begin
                for (int i = 0; i < 12; i++)
                    issue(1, 1'b1, 3'b010, 32'h40 + 32'(4 * i), 32'(i), (i != 11),
                          32'h0, 1'b0, 1'b1);
            end
            begin
                @(posedge clk);
                #1;
                issue(0, 1'b1, 3'b010, 32'h80, 32'h55, 1'b0, 32'h0, 1'b0, 1'b1);
            end
        join
        gnt_q.push_back(1); gnt_q.push_back(0);
        issue(1, 1'b0, 3'b010, 32'h60, 32'h0, 1'b0, 32'd8, 1'b0, 1'b0);
        issue(0, 1'b0, 3'b010, 32'h80, 32'h0, 1'b0, 32'h55, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        check("p0_resp_outstanding", exp0_q.size(), 32'd0);
        check("p1_resp_outstanding", exp1_q.size(), 32'd0);
        check("gnt_outstanding", gnt_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
